// File: rtl/wb_pkg.sv
// Shared encodings for the writeback stage: result-source select and load funct3 codes.
package wb_pkg;

  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10,
    RES_IMM = 2'b11
  } res_src_e;

  typedef enum logic [2:0] {
    F3_LB  = 3'b000,
    F3_LH  = 3'b001,
    F3_LW  = 3'b010,
    F3_LD  = 3'b011,
    F3_LBU = 3'b100,
    F3_LHU = 3'b101,
    F3_LWU = 3'b110
  } load_f3_e;

endpackage

// File: rtl/wb_stage_load_ext.sv
// Load-data alignment and sign/zero extension. Purely combinational.
// Byte/half/word lanes are picked by the byte offset; misaligned offsets
// simply truncate to the containing lane.
module load_ext #(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] data_i,
  input  logic [2:0]      off_i,
  input  logic [2:0]      funct3_i,
  output logic [XLEN-1:0] ext_o
);
  import wb_pkg::*;

  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic [31:0] word_v;

  // Lane select followed by extension according to funct3
  always_comb begin
    byte_v = 8'(data_i >> {off_i, 3'b000});
    half_v = 16'(data_i >> {off_i[2:1], 4'b0000});
    word_v = 32'(data_i >> {off_i[2], 5'b00000});
    ext_o  = data_i;
    case (funct3_i)
      F3_LB:  ext_o = XLEN'($signed(byte_v));
      F3_LBU: ext_o = XLEN'(byte_v);
      F3_LH:  ext_o = XLEN'($signed(half_v));
      F3_LHU: ext_o = XLEN'(half_v);
      F3_LW:  ext_o = (XLEN == 64) ? XLEN'($signed(word_v)) : data_i;
      F3_LWU: ext_o = (XLEN == 64) ? XLEN'(word_v) : data_i;
      default: ext_o = data_i;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: MEM/WB pipeline register, load extension, four-way
// result select and x0 write suppression.
// Optional retired-instruction counter enabled by defining WB_INSTRET_EN.
module wb_stage #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned REG_AW = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              StallW,
  input  logic              FlushW,
  input  logic              ValidM,
  input  logic              RegWriteM,
  input  logic [1:0]        ResultSrcM,
  input  logic [2:0]        Funct3M,
  input  logic [REG_AW-1:0] RdM,
  input  logic [XLEN-1:0]   ALUResultM,
  input  logic [XLEN-1:0]   ReadDataM,
  input  logic [XLEN-1:0]   PCPlus4M,
  input  logic [XLEN-1:0]   ImmExtM,
  output logic              ValidW,
  output logic              RegWriteW,
  output logic [REG_AW-1:0] RdW,
  output logic [XLEN-1:0]   ResultW,
  output logic [63:0]       InstRetW
);
  import wb_pkg::*;

  if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
    $error("wb_stage: XLEN must be 32 or 64");
  end

  logic              valid_q, valid_d;
  logic              regwrite_q, regwrite_d;
  logic [REG_AW-1:0] rd_q, rd_d;
  res_src_e          src_q, src_d;
  logic [2:0]        f3_q, f3_d;
  logic [XLEN-1:0]   alu_q, alu_d;
  logic [XLEN-1:0]   rdata_q, rdata_d;
  logic [XLEN-1:0]   pc4_q, pc4_d;
  logic [XLEN-1:0]   imm_q, imm_d;

  logic [2:0]        off;
  logic [XLEN-1:0]   load_val;

  // Next-state for the W register: flush beats stall, stall holds, else capture
  always_comb begin
    valid_d    = valid_q;
    regwrite_d = regwrite_q;
    rd_d       = rd_q;
    src_d      = src_q;
    f3_d       = f3_q;
    alu_d      = alu_q;
    rdata_d    = rdata_q;
    pc4_d      = pc4_q;
    imm_d      = imm_q;
    if (FlushW) begin
      valid_d    = 1'b0;
      regwrite_d = 1'b0;
      rd_d       = '0;
      src_d      = RES_ALU;
      f3_d       = '0;
      alu_d      = '0;
      rdata_d    = '0;
      pc4_d      = '0;
      imm_d      = '0;
    end else if (!StallW) begin
      valid_d    = ValidM;
      regwrite_d = RegWriteM & ValidM;
      rd_d       = RdM;
      src_d      = res_src_e'(ResultSrcM);
      f3_d       = Funct3M;
      alu_d      = ALUResultM;
      rdata_d    = ReadDataM;
      pc4_d      = PCPlus4M;
      imm_d      = ImmExtM;
    end
  end

  // W pipeline register with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q    <= 1'b0;
      regwrite_q <= 1'b0;
      rd_q       <= '0;
      src_q      <= RES_ALU;
      f3_q       <= '0;
      alu_q      <= '0;
      rdata_q    <= '0;
      pc4_q      <= '0;
      imm_q      <= '0;
    end else begin
      valid_q    <= valid_d;
      regwrite_q <= regwrite_d;
      rd_q       <= rd_d;
      src_q      <= src_d;
      f3_q       <= f3_d;
      alu_q      <= alu_d;
      rdata_q    <= rdata_d;
      pc4_q      <= pc4_d;
      imm_q      <= imm_d;
    end
  end

  assign off = (XLEN == 64) ? alu_q[2:0] : {1'b0, alu_q[1:0]};

  load_ext #(.XLEN(XLEN)) u_load_ext (
    .data_i   (rdata_q),
    .off_i    (off),
    .funct3_i (f3_q),
    .ext_o    (load_val)
  );

  // Result select feeding the register file and forwarding network
  always_comb begin
    ResultW = alu_q;
    unique case (src_q)
      RES_ALU: ResultW = alu_q;
      RES_MEM: ResultW = load_val;
      RES_PC4: ResultW = pc4_q;
      RES_IMM: ResultW = imm_q;
      default: ResultW = alu_q;
    endcase
  end

  assign ValidW    = valid_q;
  assign RdW       = rd_q;
  assign RegWriteW = regwrite_q & (rd_q != '0);

`ifdef WB_INSTRET_EN
  logic [63:0] instret_q, instret_d;

  // A W instruction retires on any unstalled edge, flushed or not
  always_comb begin
    instret_d = instret_q;
    if (valid_q && !StallW) begin
      instret_d = instret_q + 64'd1;
    end
  end

  // Retired-instruction counter, wraps naturally
  always_ff @(posedge clk) begin
    if (reset) begin
      instret_q <= '0;
    end else begin
      instret_q <= instret_d;
    end
  end

  assign InstRetW = instret_q;
`else
  assign InstRetW = '0;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Testbench for wb_stage: table-driven load/result vectors on XLEN=32 and
// XLEN=64 instances plus directed reset, x0, stall/flush and counter sequences.
module tb_wb_stage;

`ifdef WB_INSTRET_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  typedef struct {
    string       name;
    bit          is64;
    logic [1:0]  src;
    logic [2:0]  f3;
    logic [63:0] alu;
    logic [63:0] rdata;
    logic [63:0] pc4;
    logic [63:0] imm;
    logic [63:0] exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset, StallW, FlushW, ValidM, RegWriteM;
  logic [1:0]  ResultSrcM;
  logic [2:0]  Funct3M;
  logic [4:0]  RdM;
  logic [63:0] ALUResultM, ReadDataM, PCPlus4M, ImmExtM;

  logic        valid32, rw32, valid64, rw64;
  logic [4:0]  rd32, rd64;
  logic [31:0] res32;
  logic [63:0] res64, ir32, ir64;

  int unsigned n_checks = 0;
  int unsigned n_err    = 0;
  vec_t        vecs[$];

  always #5 clk = ~clk;

  wb_stage #(.XLEN(32), .REG_AW(5)) dut32 (
    .clk(clk), .reset(reset), .StallW(StallW), .FlushW(FlushW),
    .ValidM(ValidM), .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM),
    .Funct3M(Funct3M), .RdM(RdM), .ALUResultM(ALUResultM[31:0]),
    .ReadDataM(ReadDataM[31:0]), .PCPlus4M(PCPlus4M[31:0]), .ImmExtM(ImmExtM[31:0]),
    .ValidW(valid32), .RegWriteW(rw32), .RdW(rd32), .ResultW(res32), .InstRetW(ir32)
  );

  wb_stage #(.XLEN(64), .REG_AW(5)) dut64 (
    .clk(clk), .reset(reset), .StallW(StallW), .FlushW(FlushW),
    .ValidM(ValidM), .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM),
    .Funct3M(Funct3M), .RdM(RdM), .ALUResultM(ALUResultM),
    .ReadDataM(ReadDataM), .PCPlus4M(PCPlus4M), .ImmExtM(ImmExtM),
    .ValidW(valid64), .RegWriteW(rw64), .RdW(rd64), .ResultW(res64), .InstRetW(ir64)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_m(input logic v, input logic rw, input logic [1:0] src,
                       input logic [2:0] f3, input logic [4:0] rd,
                       input logic [63:0] alu, input logic [63:0] rdata,
                       input logic [63:0] pc4, input logic [63:0] imm);
    ValidM     = v;
    RegWriteM  = rw;
    ResultSrcM = src;
    Funct3M    = f3;
    RdM        = rd;
    ALUResultM = alu;
    ReadDataM  = rdata;
    PCPlus4M   = pc4;
    ImmExtM    = imm;
  endtask

  function automatic vec_t mk(input string name, input bit is64, input logic [1:0] src,
                              input logic [2:0] f3, input logic [63:0] alu,
                              input logic [63:0] rdata, input logic [63:0] exp);
    vec_t v;
    v.name  = name;
    v.is64  = is64;
    v.src   = src;
    v.f3    = f3;
    v.alu   = alu;
    v.rdata = rdata;
    v.pc4   = 64'd2;
    v.imm   = 64'h1234_5000;
    v.exp   = exp;
    return v;
  endfunction

  initial begin
    logic [63:0] d32;
    logic [63:0] d64;
    d32 = 64'h0000_0000_8070_F0A5;
    d64 = 64'hF0E1_D2C3_8070_F0A5;

    // XLEN=32 loads and result sources
    vecs.push_back(mk("lb_off3",     0, 2'b01, 3'b000, 64'h1000_0003, d32, 64'hFFFF_FF80));
    vecs.push_back(mk("lbu_off3",    0, 2'b01, 3'b100, 64'h1000_0003, d32, 64'h0000_0080));
    vecs.push_back(mk("lh_off2",     0, 2'b01, 3'b001, 64'h1000_0002, d32, 64'hFFFF_8070));
    vecs.push_back(mk("lb_off0",     0, 2'b01, 3'b000, 64'h1000_0000, d32, 64'hFFFF_FFA5));
    vecs.push_back(mk("lbu_off1",    0, 2'b01, 3'b100, 64'h1000_0001, d32, 64'h0000_00F0));
    vecs.push_back(mk("lh_off0",     0, 2'b01, 3'b001, 64'h1000_0000, d32, 64'hFFFF_F0A5));
    vecs.push_back(mk("lhu_off0",    0, 2'b01, 3'b101, 64'h1000_0000, d32, 64'h0000_F0A5));
    vecs.push_back(mk("lhu_off3",    0, 2'b01, 3'b101, 64'h1000_0003, d32, 64'h0000_8070));
    vecs.push_back(mk("lbu_bit2",    0, 2'b01, 3'b100, 64'h0000_0107, d32, 64'h0000_0080));
    vecs.push_back(mk("lw_32",       0, 2'b01, 3'b010, 64'h1000_0001, d32, 64'h8070_F0A5));
    vecs.push_back(mk("lwu_32",      0, 2'b01, 3'b110, 64'h1000_0000, d32, 64'h8070_F0A5));
    vecs.push_back(mk("ld_32",       0, 2'b01, 3'b011, 64'h1000_0000, d32, 64'h8070_F0A5));
    vecs.push_back(mk("f3_111_32",   0, 2'b01, 3'b111, 64'h1000_0002, d32, 64'h8070_F0A5));
    vecs.push_back(mk("src_alu",     0, 2'b00, 3'b000, 64'h0000_0001, d32, 64'h0000_0001));
    vecs.push_back(mk("src_pc4",     0, 2'b10, 3'b000, 64'h0000_0001, d32, 64'h0000_0002));
    vecs.push_back(mk("src_imm",     0, 2'b11, 3'b000, 64'h0000_0001, d32, 64'h1234_5000));
    // XLEN=64 loads
    vecs.push_back(mk("lb_off7_64",  1, 2'b01, 3'b000, 64'h2000_0007, d64, 64'hFFFF_FFFF_FFFF_FFF0));
    vecs.push_back(mk("lbu_off5_64", 1, 2'b01, 3'b100, 64'h2000_0005, d64, 64'h0000_0000_0000_00D2));
    vecs.push_back(mk("lh_off6_64",  1, 2'b01, 3'b001, 64'h2000_0006, d64, 64'hFFFF_FFFF_FFFF_F0E1));
    vecs.push_back(mk("lhu_off4_64", 1, 2'b01, 3'b101, 64'h2000_0004, d64, 64'h0000_0000_0000_D2C3));
    vecs.push_back(mk("lw_off0_64",  1, 2'b01, 3'b010, 64'h2000_0000, d64, 64'hFFFF_FFFF_8070_F0A5));
    vecs.push_back(mk("lwu_off0_64", 1, 2'b01, 3'b110, 64'h2000_0000, d64, 64'h0000_0000_8070_F0A5));
    vecs.push_back(mk("lw_off4_64",  1, 2'b01, 3'b010, 64'h2000_0004, d64, 64'hFFFF_FFFF_F0E1_D2C3));
    vecs.push_back(mk("lwu_off5_64", 1, 2'b01, 3'b110, 64'h2000_0005, d64, 64'h0000_0000_F0E1_D2C3));
    vecs.push_back(mk("ld_64",       1, 2'b01, 3'b011, 64'h2000_0003, d64, d64));
    vecs.push_back(mk("f3_111_64",   1, 2'b01, 3'b111, 64'h2000_0001, d64, d64));
    vecs.push_back(mk("src_imm_64",  1, 2'b11, 3'b000, 64'h0000_0001, d64, 64'h1234_5000));

    // Reset held two cycles with busy M inputs
    reset  = 1'b1;
    StallW = 1'b0;
    FlushW = 1'b0;
    set_m(1'b1, 1'b1, 2'b10, 3'b000, 5'd7, 64'hDEAD_BEEF, d64, 64'h44, 64'h55);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("rst_valid", {63'd0, valid32}, 64'd0);
      chk("rst_regwrite", {63'd0, rw32}, 64'd0);
      chk("rst_rd", {59'd0, rd32}, 64'd0);
      chk("rst_result", {32'd0, res32}, 64'd0);
      chk("rst_instret", ir32, 64'd0);
    end
    reset = 1'b0;

    // Table-driven vectors, one instruction per cycle
    for (int i = 0; i < vecs.size(); i++) begin
      logic [4:0] rd;
      rd = 5'((i % 31) + 1);
      set_m(1'b1, 1'b1, vecs[i].src, vecs[i].f3, rd, vecs[i].alu, vecs[i].rdata,
            vecs[i].pc4, vecs[i].imm);
      tick();
      if (vecs[i].is64) begin
        chk(vecs[i].name, res64, vecs[i].exp);
        chk({vecs[i].name, "_rd"}, {59'd0, rd64}, {59'd0, rd});
      end else begin
        chk(vecs[i].name, {32'd0, res32}, vecs[i].exp);
        chk({vecs[i].name, "_rd"}, {59'd0, rd32}, {59'd0, rd});
      end
    end

    // x0 write suppression and valid gating
    set_m(1'b1, 1'b1, 2'b00, 3'b000, 5'd0, 64'h11, 64'h0, 64'h0, 64'h0);
    tick();
    chk("x0_valid", {63'd0, valid32}, 64'd1);
    chk("x0_regwrite", {63'd0, rw32}, 64'd0);
    set_m(1'b1, 1'b1, 2'b00, 3'b000, 5'd5, 64'h11, 64'h0, 64'h0, 64'h0);
    tick();
    chk("rd5_regwrite", {63'd0, rw32}, 64'd1);
    chk("rd5_rd", {59'd0, rd32}, 64'd5);
    set_m(1'b0, 1'b1, 2'b00, 3'b000, 5'd5, 64'h11, 64'h0, 64'h0, 64'h0);
    tick();
    chk("inval_valid", {63'd0, valid32}, 64'd0);
    chk("inval_regwrite", {63'd0, rw32}, 64'd0);

    // Stall holds A while B is presented, then flush beats stall
    set_m(1'b1, 1'b1, 2'b00, 3'b000, 5'd3, 64'h0000_AAAA, 64'h0, 64'h0, 64'h0);
    tick();
    StallW = 1'b1;
    set_m(1'b1, 1'b1, 2'b11, 3'b000, 5'd4, 64'h0000_BBBB, 64'h0, 64'h0, 64'h0000_CCCC);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_result", {32'd0, res32}, 64'h0000_AAAA);
      chk("stall_rd", {59'd0, rd32}, 64'd3);
      chk("stall_valid", {63'd0, valid32}, 64'd1);
    end
    FlushW = 1'b1;
    tick();
    chk("flush_valid", {63'd0, valid32}, 64'd0);
    chk("flush_regwrite", {63'd0, rw32}, 64'd0);
    chk("flush_result", {32'd0, res32}, 64'd0);
    FlushW = 1'b0;
    StallW = 1'b0;

    // Retired-instruction counting: 10 valid instructions with 2 stall cycles
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("cnt_reset", ir32, 64'd0);
    for (int i = 0; i < 10; i++) begin
      if (i == 4) begin
        StallW = 1'b1;
        tick();
        tick();
        StallW = 1'b0;
        chk("cnt_stalled", ir32, CNT_EN ? 64'd3 : 64'd0);
      end
      set_m(1'b1, 1'b1, 2'b00, 3'b000, 5'(i + 1), 64'(i), 64'h0, 64'h0, 64'h0);
      tick();
    end
    set_m(1'b0, 1'b0, 2'b00, 3'b000, 5'd0, 64'h0, 64'h0, 64'h0, 64'h0);
    tick();
    tick();
    chk("cnt_ten", ir32, CNT_EN ? 64'd10 : 64'd0);
    chk("cnt_ten_64", ir64, CNT_EN ? 64'd10 : 64'd0);

    // Wrap from all-ones, then a flushed retiring instruction still counts
    set_m(1'b1, 1'b1, 2'b00, 3'b000, 5'd1, 64'h1, 64'h0, 64'h0, 64'h0);
    tick();
`ifdef WB_INSTRET_EN
    dut32.instret_q = '1;
`endif
    set_m(1'b0, 1'b0, 2'b00, 3'b000, 5'd0, 64'h0, 64'h0, 64'h0, 64'h0);
    tick();
    chk("cnt_wrap", ir32, 64'd0);
    set_m(1'b1, 1'b1, 2'b00, 3'b000, 5'd1, 64'h1, 64'h0, 64'h0, 64'h0);
    tick();
    FlushW = 1'b1;
    tick();
    FlushW = 1'b0;
    chk("cnt_flush", ir32, CNT_EN ? 64'd1 : 64'd0);
    chk("cnt_flush_valid", {63'd0, valid32}, 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
